// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access unit: access sizes, FSM states and the
// alignment/legality check applied at request accept.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MERGE,
    ST_WRITE,
    ST_RESP
  } state_e;

  // True for misaligned half/word accesses and the reserved size code.
  function automatic logic req_bad(input size_e size, input logic [1:0] lane);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = lane[0];
      SIZE_WORD: bad = (lane != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane.sv
// Combinational little-endian lane logic: load extraction with sign/zero
// extension, and sub-word merge of store data into the current RAM word.
module byte_lane_unit
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [15:0] new_data,
  input  logic [1:0]  lane,
  input  size_e       size,
  input  logic        sign,
  output logic [31:0] ext,
  output logic [31:0] merged
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {lane, 3'b000};
    ext     = word;
    merged  = word;
    case (size)
      SIZE_BYTE: begin
        ext = {{24{sign & shifted[7]}}, shifted[7:0]};
        merged[{lane, 3'b000} +: 8] = new_data[7:0];
      end
      SIZE_HALF: begin
        ext = {{16{sign & shifted[15]}}, shifted[15:0]};
        merged[{lane[1], 4'b0000} +: 16] = new_data;
      end
      default: begin
        ext    = word;
        merged = word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of a read-first synchronous RAM port: byte/half/word loads and
// stores over valid/ready, with read-modify-write merging for sub-word stores.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int data_width = 32,
  parameter int addr_width = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [data_width-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [data_width-1:0] resp_rdata,
  output logic [addr_width-1:0] mem_read_address,
  output logic [addr_width-1:0] mem_write_address,
  output logic                  mem_write,
  output logic [data_width-1:0] mem_din,
  input  logic [data_width-1:0] mem_dout
);

  state_e                state_q, state_d;
  size_e                 size_q;
  logic                  signed_q;
  logic [1:0]            lane_q;
  logic [15:0]           wdata_q;
  logic                  err_q;
  logic                  accept;
  logic                  bad;
  logic [addr_width-1:0] req_idx;
  logic [31:0]           lane_ext;
  logic [31:0]           lane_merged;

  // Upper address bits alias onto the RAM; they intentionally play no role.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:addr_width+2], req_wdata[data_width-1:16]};

  assign req_idx = req_addr[addr_width+1:2];
  assign accept  = (state_q == ST_IDLE) && req_valid;
  assign bad     = req_bad(size_e'(req_size), req_addr[1:0]);

  byte_lane_unit u_lane (
    .word     (mem_dout),
    .new_data (wdata_q),
    .lane     (lane_q),
    .size     (size_q),
    .sign     (signed_q),
    .ext      (lane_ext),
    .merged   (lane_merged)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q           <= ST_IDLE;
      size_q            <= SIZE_BYTE;
      signed_q          <= 1'b0;
      lane_q            <= '0;
      wdata_q           <= '0;
      err_q             <= 1'b0;
      resp_rdata        <= '0;
      mem_din           <= '0;
      mem_write_address <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        size_q            <= size_e'(req_size);
        signed_q          <= req_signed;
        lane_q            <= req_addr[1:0];
        wdata_q           <= req_wdata[15:0];
        err_q             <= bad;
        mem_write_address <= req_idx;
      end
      // resp_rdata only changes on entry to RESP so it holds between responses.
      if (state_q == ST_LOAD) begin
        resp_rdata <= lane_ext;
      end else if (state_d == ST_RESP) begin
        resp_rdata <= '0;
      end
      if (accept && (state_d == ST_WRITE)) begin
        mem_din <= req_wdata;
      end else if (state_q == ST_MERGE) begin
        mem_din <= lane_merged;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (bad)                               state_d = ST_RESP;
          else if (!req_write)                   state_d = ST_LOAD;
          else if (size_e'(req_size) == SIZE_WORD) state_d = ST_WRITE;
          else                                   state_d = ST_MERGE;
        end
      end
      ST_LOAD:  state_d = ST_RESP;
      ST_MERGE: state_d = ST_WRITE;
      ST_WRITE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_RESP);
    resp_err   = (state_q == ST_RESP) && err_q;
    // Gated by resetn so a reset landing on WRITE never reaches the RAM.
    mem_write  = (state_q == ST_WRITE) && resetn;
    if (!resetn)
      mem_read_address = '0;
    else if (state_q == ST_IDLE)
      mem_read_address = req_idx;
    else
      mem_read_address = mem_write_address;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: memory_access_unit against a behavioural read-first RAM with
// mem[1] preloaded; hand-computed expectations for latency, data and errors.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [3:0]  mem_read_address;
  logic [3:0]  mem_write_address;
  logic        mem_write;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  logic [31:0] ram [16];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) ram[mem_write_address] <= mem_din;
    mem_dout <= ram[mem_read_address];
  end

  mem_access_unit #(.data_width(32), .addr_width(4)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_size          (req_size),
    .req_signed        (req_signed),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .resp_valid        (resp_valid),
    .resp_err          (resp_err),
    .resp_rdata        (resp_rdata),
    .mem_read_address  (mem_read_address),
    .mem_write_address (mem_write_address),
    .mem_write         (mem_write),
    .mem_din           (mem_din),
    .mem_dout          (mem_dout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request at c0 and follow it to its response; exp_wr is the
  // cycle index where mem_write is expected (0 = never). With noise set,
  // junk requests are held on the inputs while the unit is busy.
  task automatic run_req(input string tag, input logic w, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd,
                         input int exp_lat, input int exp_wr, input logic [31:0] exp_din,
                         input logic exp_err, input logic [31:0] exp_rd, input logic noise);
    int lat = 0;
    int wrc = 0;
    int wrcount = 0;
    logic busy_ready = 1'b0;
    logic [31:0] din_seen = '0;
    check({tag, ".ready_c0"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 6 && lat == 0; k++) begin
      if (mem_write) begin wrc = k; wrcount++; din_seen = mem_din; end
      if (req_ready) busy_ready = 1'b1;
      if (resp_valid) begin
        lat = k;
        req_valid = 1'b0;
        check({tag, ".err"}, {31'b0, resp_err}, {31'b0, exp_err});
        check({tag, ".rdata"}, resp_rdata, exp_rd);
      end else begin
        if (noise) begin
          req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
          req_addr = 32'h4; req_wdata = 32'h5555_AAAA;
        end
        @(posedge clk); #1;
      end
    end
    req_valid = 1'b0;
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".write_cycle"}, wrc, exp_wr);
    check({tag, ".write_count"}, wrcount, (exp_wr != 0) ? 1 : 0);
    if (exp_wr != 0) check({tag, ".din"}, din_seen, exp_din);
    check({tag, ".busy_not_ready"}, {31'b0, busy_ready}, 32'd0);
    @(posedge clk); #1;
    check({tag, ".resp_one_cycle"}, {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 32'h0;
    ram[1] = 32'h8081_F2F3;
    resetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", {31'b0, req_ready}, 32'd1);
    check("rst.resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst.resp_err", {31'b0, resp_err}, 32'd0);
    check("rst.rdata", resp_rdata, 32'h0);
    check("rst.din", mem_din, 32'h0);
    check("rst.mem_write", {31'b0, mem_write}, 32'd0);
    check("rst.waddr", {28'b0, mem_write_address}, 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;

    //      tag        w     sz     sg    addr   wdata          lat wr din            err   rdata          noise
    run_req("ldw4",    1'b0, 2'b10, 1'b0, 32'h4, 32'h0,          2, 0, 32'h0,         1'b0, 32'h8081_F2F3, 1'b0);
    run_req("ldbs5",   1'b0, 2'b00, 1'b1, 32'h5, 32'h0,          2, 0, 32'h0,         1'b0, 32'hFFFF_FFF2, 1'b0);
    run_req("ldbu5",   1'b0, 2'b00, 1'b0, 32'h5, 32'h0,          2, 0, 32'h0,         1'b0, 32'h0000_00F2, 1'b0);
    run_req("ldhs6",   1'b0, 2'b01, 1'b1, 32'h6, 32'h0,          2, 0, 32'h0,         1'b0, 32'hFFFF_8081, 1'b0);
    run_req("ldhu6",   1'b0, 2'b01, 1'b0, 32'h6, 32'h0,          2, 0, 32'h0,         1'b0, 32'h0000_8081, 1'b0);
    run_req("stb6",    1'b1, 2'b00, 1'b0, 32'h6, 32'h0000_00AA,  3, 2, 32'h80AA_F2F3, 1'b0, 32'h0,         1'b0);
    run_req("ldw4b",   1'b0, 2'b10, 1'b0, 32'h4, 32'h0,          2, 0, 32'h0,         1'b0, 32'h80AA_F2F3, 1'b1);
    run_req("ldh5err", 1'b0, 2'b01, 1'b1, 32'h5, 32'h0,          1, 0, 32'h0,         1'b1, 32'h0,         1'b0);
    run_req("stw6err", 1'b1, 2'b10, 1'b0, 32'h6, 32'hFFFF_FFFF,  1, 0, 32'h0,         1'b1, 32'h0,         1'b0);
    run_req("sz11err", 1'b0, 2'b11, 1'b0, 32'h4, 32'h0,          1, 0, 32'h0,         1'b1, 32'h0,         1'b0);
    run_req("stw44",   1'b1, 2'b10, 1'b0, 32'h44,32'h1234_5678,  2, 1, 32'h1234_5678, 1'b0, 32'h0,         1'b0);
    run_req("ldw4c",   1'b0, 2'b10, 1'b0, 32'h4, 32'h0,          2, 0, 32'h0,         1'b0, 32'h1234_5678, 1'b0);
    run_req("sth4",    1'b1, 2'b01, 1'b0, 32'h4, 32'hFFFF_BEEF,  3, 2, 32'h1234_BEEF, 1'b0, 32'h0,         1'b1);
    run_req("ldbu7",   1'b0, 2'b00, 1'b0, 32'h7, 32'h0,          2, 0, 32'h0,         1'b0, 32'h0000_0012, 1'b0);
    run_req("ldbs4",   1'b0, 2'b00, 1'b1, 32'h4, 32'h0,          2, 0, 32'h0,         1'b0, 32'hFFFF_FFEF, 1'b0);
    check("mem1_after_merge", ram[1], 32'h1234_BEEF);

    // Reset landing on the WRITE cycle of a word store must suppress the write.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h4; req_wdata = 32'hCAFE_BABE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort.write_state", {31'b0, mem_write}, 32'd1);
    resetn = 1'b0;
    #1;
    check("abort.write_gated", {31'b0, mem_write}, 32'd0);
    @(posedge clk); #1;
    check("abort.ready", {31'b0, req_ready}, 32'd1);
    check("abort.resp_valid", {31'b0, resp_valid}, 32'd0);
    check("abort.mem1", ram[1], 32'h1234_BEEF);
    resetn = 1'b1;
    @(posedge clk); #1;
    run_req("ldw4d",   1'b0, 2'b10, 1'b0, 32'h4, 32'h0,          2, 0, 32'h0,         1'b0, 32'h1234_BEEF, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
